// File: rtl/inverse_kinematics_search.sv
// Exhaustive 3-link planar IK search over the 9-entry angle table.
// One candidate per clock, start/busy/done handshake, registered result.
module inverse_kinematics_search #(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic signed [31:0] target_x,
   input  logic signed [31:0] target_y,
   input  logic signed [15:0] L1,
   input  logic signed [15:0] L2,
   input  logic signed [15:0] L3,
   output logic               busy,
   output logic               done,
   output logic signed [15:0] theta1,
   output logic signed [15:0] theta2,
   output logic signed [15:0] theta3,
   output logic        [33:0] err,
   output logic               exact
);

   typedef enum logic [1:0] {IDLE, SEARCH, FIN} state_t;

   state_t state, state_nxt;

   logic signed [31:0] cap_x, cap_y;
   logic signed [15:0] cap_l1, cap_l2, cap_l3;
   logic        [3:0]  idx_i, idx_j, idx_k;
   logic        [33:0] best_err;
   logic signed [15:0] best_t1, best_t2, best_t3;

   logic signed [15:0] t1, t12, t123;
   logic signed [31:0] l1_w, l2_w, l3_w;
   logic signed [31:0] sum_x, sum_y, pos_x, pos_y;
   logic signed [33:0] dx, dy;
   logic        [33:0] ax, ay, cand_err;
   logic               better, last_cand, hit, finish;
   logic        [33:0] fin_err;

   function automatic logic signed [15:0] ang_of(input logic [3:0] idx);
      case (idx)
         4'd0:    return 16'sd0;
         4'd1:    return 16'sd30;
         4'd2:    return 16'sd45;
         4'd3:    return 16'sd60;
         4'd4:    return 16'sd90;
         4'd5:    return 16'sd120;
         4'd6:    return 16'sd135;
         4'd7:    return 16'sd150;
         4'd8:    return 16'sd180;
         default: return 16'sd0;
      endcase
   endfunction

   // Angles outside the table (including sums past 180) contribute nothing.
   function automatic logic signed [31:0] cos_of(input logic signed [15:0] a);
      case (a)
         16'sd0:   return 32'sd1000;
         16'sd30:  return 32'sd866;
         16'sd45:  return 32'sd707;
         16'sd60:  return 32'sd500;
         16'sd90:  return 32'sd0;
         16'sd120: return -32'sd500;
         16'sd135: return -32'sd707;
         16'sd150: return -32'sd866;
         16'sd180: return -32'sd1000;
         default:  return 32'sd0;
      endcase
   endfunction

   function automatic logic signed [31:0] sin_of(input logic signed [15:0] a);
      case (a)
         16'sd0:   return 32'sd0;
         16'sd30:  return 32'sd500;
         16'sd45:  return 32'sd707;
         16'sd60:  return 32'sd866;
         16'sd90:  return 32'sd1000;
         16'sd120: return 32'sd866;
         16'sd135: return 32'sd707;
         16'sd150: return 32'sd500;
         16'sd180: return 32'sd0;
         default:  return 32'sd0;
      endcase
   endfunction

   // Forward model and L1 error of the current candidate.
   always_comb begin
      t1    = ang_of(idx_i);
      t12   = t1 + ang_of(idx_j);
      t123  = t12 + ang_of(idx_k);
      l1_w  = {{16{cap_l1[15]}}, cap_l1};
      l2_w  = {{16{cap_l2[15]}}, cap_l2};
      l3_w  = {{16{cap_l3[15]}}, cap_l3};
      sum_x = l1_w * cos_of(t1) + l2_w * cos_of(t12) + l3_w * cos_of(t123);
      sum_y = l1_w * sin_of(t1) + l2_w * sin_of(t12) + l3_w * sin_of(t123);
      pos_x = sum_x / 32'sd1000;
      pos_y = sum_y / 32'sd1000;
      dx    = {{2{pos_x[31]}}, pos_x} - {{2{cap_x[31]}}, cap_x};
      dy    = {{2{pos_y[31]}}, pos_y} - {{2{cap_y[31]}}, cap_y};
      ax    = dx[33] ? 34'(-dx) : 34'(dx);
      ay    = dy[33] ? 34'(-dy) : 34'(dy);
      cand_err  = ax + ay;
      better    = cand_err < best_err;
      last_cand = (idx_i == 4'd8) && (idx_j == 4'd8) && (idx_k == 4'd8);
      hit       = EARLY_EXIT && (cand_err == 34'd0);
      finish    = last_cand || hit;
      fin_err   = better ? cand_err : best_err;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SEARCH;
         SEARCH:  if (finish) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SEARCH);
   assign done = (state == FIN);

   // Input capture, candidate stepping, best tracking and result load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_x    <= '0;
         cap_y    <= '0;
         cap_l1   <= '0;
         cap_l2   <= '0;
         cap_l3   <= '0;
         idx_i    <= '0;
         idx_j    <= '0;
         idx_k    <= '0;
         best_err <= '0;
         best_t1  <= '0;
         best_t2  <= '0;
         best_t3  <= '0;
         theta1   <= '0;
         theta2   <= '0;
         theta3   <= '0;
         err      <= '0;
         exact    <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            cap_x    <= target_x;
            cap_y    <= target_y;
            cap_l1   <= L1;
            cap_l2   <= L2;
            cap_l3   <= L3;
            idx_i    <= '0;
            idx_j    <= '0;
            idx_k    <= '0;
            best_err <= '1;
         end
      end else if (state == SEARCH) begin
         if (better) begin
            best_err <= cand_err;
            best_t1  <= t1;
            best_t2  <= ang_of(idx_j);
            best_t3  <= ang_of(idx_k);
         end
         if (idx_k == 4'd8) begin
            idx_k <= '0;
            if (idx_j == 4'd8) begin
               idx_j <= '0;
               idx_i <= idx_i + 4'd1;
            end else begin
               idx_j <= idx_j + 4'd1;
            end
         end else begin
            idx_k <= idx_k + 4'd1;
         end
         if (finish) begin
            theta1 <= better ? t1 : best_t1;
            theta2 <= better ? ang_of(idx_j) : best_t2;
            theta3 <= better ? ang_of(idx_k) : best_t3;
            err    <= fin_err;
            exact  <= (fin_err == 34'd0);
         end
      end
   end

endmodule

// File: tb/tb_inverse_kinematics_search.sv
// Directed bench for inverse_kinematics_search.
// Hand-computed targets, latencies and results.
module tb_inverse_kinematics_search;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [31:0] target_x, target_y;
   logic signed [15:0] L1, L2, L3;
   logic               busy, done, exact;
   logic signed [15:0] theta1, theta2, theta3;
   logic        [33:0] err;

   int checks = 0;
   int failures = 0;

   inverse_kinematics_search dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .target_x (target_x),
      .target_y (target_y),
      .L1       (L1),
      .L2       (L2),
      .L3       (L3),
      .busy     (busy),
      .done     (done),
      .theta1   (theta1),
      .theta2   (theta2),
      .theta3   (theta3),
      .err      (err),
      .exact    (exact)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic run_search(input int x, input int y, input int lat,
                             input int e1, input int e2, input int e3,
                             input longint e_err, input bit disturb);
      int cyc;
      bit seen;
      @(negedge clk);
      target_x = x;
      target_y = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      seen = 1'b0;
      while (cyc < 800 && !seen) begin
         if (disturb && cyc == 40) begin
            target_x = -77;
            target_y = 5;
            start = 1'b1;
         end
         if (disturb && cyc == 41) start = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1'b1;
      end
      check("done_seen", longint'(seen), 1);
      check("latency", cyc, lat);
      check("busy_in_done", longint'(busy), 0);
      check("theta1", theta1, e1);
      check("theta2", theta2, e2);
      check("theta3", theta3, e3);
      check("err", longint'(err), e_err);
      check("exact", longint'(exact), longint'(e_err == 0));
      if (disturb) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("done_one_cycle", longint'(done), 0);
      check("theta1_hold", theta1, e1);
      @(posedge clk);
      #1;
      check("no_queued_start", longint'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      target_x = '0;
      target_y = '0;
      L1 = 16'sd100;
      L2 = 16'sd100;
      L3 = 16'sd100;
      #23 rst_n = 1'b1;

      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("reset_state",
               longint'({busy, done, exact, err, theta1, theta2, theta3}), 0);
      end

      run_search(300, 0, 1, 0, 0, 0, 0, 1'b0);
      run_search(100, 0, 9, 0, 0, 180, 0, 1'b0);
      run_search(0, 300, 325, 90, 0, 0, 0, 1'b1);
      run_search(1000, 1000, 729, 45, 0, 0, 1576, 1'b0);

      @(negedge clk);
      target_x = 1000;
      target_y = 1000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_err", longint'(err), 0);
      check("rst_theta1", theta1, 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("rst_no_done", longint'({busy, done}), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      run_search(100, 0, 9, 0, 0, 180, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
